// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: diff = a - b - bin, LSB first, one bit per clock
// through a single subtractor cell with a registered borrow and start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, r_sr_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;

  logic             d_bit;
  logic             br_d;
  logic [WIDTH:0]   r_cat;
  logic [WIDTH-1:0] r_sr_d;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs; the new bit enters the result at the MSB.
  assign d_bit    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
  assign br_d     = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  assign r_cat    = {d_bit, r_sr_q};
  assign r_sr_d   = r_cat[WIDTH:1];
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          br_q   <= br_d;
          r_sr_q <= r_sr_d;
          cnt_q  <= cnt_q + CW'(1);
          // diff/bout are only touched here, so they hold the previous result meanwhile.
          if (last_bit) begin
            diff    <= r_sr_d;
            bout    <= br_d;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit instance for arithmetic, ignore-start and abort
// scenarios, plus a 1-bit instance exercising the full-subtractor truth table back-to-back.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] last8 = '0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  // Scoreboard for the 8-bit instance: every done pops one expected result.
  always @(negedge clk) begin
    if (!rst && done8 === 1'b1) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL done8_unexpected: got done with {bout,diff}=%h, required no done", {bout8, diff8});
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        if ({bout8, diff8} !== e) begin
          errors++;
          $display("FAIL result8: got {bout,diff}=%h, required %h", {bout8, diff8}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL done1_unexpected: got done with {bout,diff}=%b, required no done", {bout1, diff1});
      end else begin
        logic [1:0] e;
        e = q1.pop_front();
        if ({bout1, diff1} !== e) begin
          errors++;
          $display("FAIL result1: got {bout,diff}=%b, required %b", {bout1, diff1}, e);
        end
      end
    end
  end

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {8'b0, bin};
  endfunction

  // One complete 8-bit operation; returns edges from the start edge to the done cycle.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin, output int lat);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    q8.push_back(model8(a, b, bin));
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b, required 1", busy8);
    end
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat >= 40) begin
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", lat);
    end
    last8 = model8(a, b, bin);
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: got busy=%b done=%b, required 0 0", busy8, done8);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy8, done8, bout8, diff8} !== 11'h0 || {busy1, done1, bout1, diff1} !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: got w8=%h w1=%h, required 0 0",
               {busy8, done8, bout8, diff8}, {busy1, done1, bout1, diff1});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    run_op8(8'h05, 8'h03, 1'b0, lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL latency: got %0d edges, required 9", lat);
    end
  endtask

  task automatic test_arith();
    logic [16:0] vec [5];
    int lat;
    vec = '{{8'h03, 8'h05, 1'b0}, {8'h00, 8'h00, 1'b1}, {8'hFF, 8'hFF, 1'b0},
            {8'h80, 8'h01, 1'b1}, {8'h5A, 8'hC3, 1'b1}};
    foreach (vec[i]) begin
      run_op8(vec[i][16:9], vec[i][8:1], vec[i][0], lat);
    end
  endtask

  task automatic test_ignore_start();
    int c;
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(8'h10, 8'h01, 1'b0));
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1; start8 = 1'b0;
    c = 1;
    while (done8 !== 1'b1 && c < 40) begin
      checks++;
      if ({bout8, diff8} !== last8) begin
        errors++;
        $display("FAIL hold_before_done: got %h, required %h", {bout8, diff8}, last8);
      end
      start8 = (c == 3 || c == 5);
      @(negedge clk);
      c++;
    end
    start8 = 1'b0;
    checks++;
    if (c >= 40) begin
      errors++;
      $display("FAIL ignore_timeout: got no done, required done");
    end
    last8 = model8(8'h10, 8'h01, 1'b0);
    repeat (12) @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_restarted: got busy=%b, required 0", busy8);
    end
  endtask

  task automatic test_abort();
    int lat;
    int ndone = 0;
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, bout8, diff8} !== 11'h0) begin
      errors++;
      $display("FAIL async_abort: got %h, required 0", {busy8, done8, bout8, diff8});
    end
    @(negedge clk);
    rst = 1'b0;
    last8 = '0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL done_after_abort: got %0d dones, required 0", ndone);
    end
    run_op8(8'h20, 8'h01, 1'b0, lat);
  endtask

  task automatic test_back_to_back_w1();
    time t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
      q1.push_back(2'({1'b0, v[2]} - {1'b0, v[1]} - {1'b0, v[0]}));
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b1) begin
        errors++;
        $display("FAIL w1_done_timing op%0d: got done=%b busy=%b, required 1 1", i, done1, busy1);
      end
      if (i > 0) begin
        checks++;
        if ($time - t_prev != 30) begin
          errors++;
          $display("FAIL w1_period op%0d: got %0t, required 30", i, $time - t_prev);
        end
      end
      t_prev = $time;
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_idle op%0d: got done=%b busy=%b, required 0 0", i, done1, busy1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_ignore_start();
    test_abort();
    test_back_to_back_w1();
    repeat (5) @(negedge clk);
    checks++;
    if (q8.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", q8.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
